sha3_digest_squeezer: RTL and testbench
=======================================

Name: sha3_digest_squeezer

Overview:
- Consumer end of the permutation core's output interface. Captures the 1600-bit Keccak state on the single-cycle HASH_VALID pulse.
- Serialises the first DIGEST_SIZE bits as WORD_WIDTH-bit words over a valid/ready stream to the host/bus side.
- Drives BUSY back toward the padding/permutation front end so a new hash is not finalised while the current digest is still draining.

Parameters:
- DIGEST_SIZE, 256, digest length in bits. Multiple of 8, range 8..1600 (224/256/384/512 for SHA3 variants).
- WORD_WIDTH, 64, output word width in bits. Multiple of 8, range 8..256.
- BYTE_SWAP, 0, if 1 reverses byte order within each output word (byte 0 of word to DOUT[WORD_WIDTH-8 +: 8] becomes DOUT[0 +: 8]); if 0 no reordering.

Ports:
- CLK  input  1  clock, rising edge.
- A_RST  input  1  asynchronous active-high reset.
- CE  input  1  clock enable. When 0, all registers hold.
- STATE_IN  input  [0:1599]  permutation state, index 0 is the first state bit.
- HASH_VALID  input  1  one-cycle pulse: STATE_IN holds the final hash state.
- DOUT  output  [0:WORD_WIDTH-1]  current digest word.
- DOUT_VALID  output  1  DOUT holds a valid word.
- DOUT_READY  input  1  downstream accepts the word.
- DOUT_LAST  output  1  DOUT is the final word of the digest.
- BUSY  output  1  digest is being drained; upstream must not pulse HASH_VALID.
- OVERFLOW  output  1  sticky flag: a HASH_VALID was dropped.
- CLR_OVERFLOW  input  1  synchronous clear of OVERFLOW (CE-qualified).

Behaviour:
- N = ceil(DIGEST_SIZE/WORD_WIDTH).
- Word k = STATE_IN[k*WORD_WIDTH +: WORD_WIDTH]. The final partial word is zero-filled at higher indices, then BYTE_SWAP is applied.
- Reset (async, immediate): state IDLE, word index 0, capture buffer 0, DOUT=0, DOUT_VALID=0, DOUT_LAST=0, BUSY=0, OVERFLOW=0.
- Reset mid-transfer aborts the digest. DOUT_VALID drops without waiting for a clock.
- CE=0: FSM, index, buffer, outputs and OVERFLOW all frozen. Handshakes only complete with CE=1.
- Two-state FSM, IDLE and SEND. A transfer is DOUT_VALID & DOUT_READY & CE.
- IDLE:
  - HASH_VALID=1 captures STATE_IN[0:DIGEST_SIZE-1] into the buffer.
  - Index becomes 0; next cycle enter SEND with DOUT=word0, DOUT_VALID=1, BUSY=1.
  - Latency HASH_VALID to first DOUT_VALID is 1 cycle.
- SEND:
  - DOUT, DOUT_VALID and DOUT_LAST are registered.
  - While DOUT_READY=0, DOUT and DOUT_LAST hold stable.
  - On a transfer with index < N-1: index+1; next-cycle DOUT=word[index+1]. No bubbles; with READY=1 continuously, one word per cycle.
  - DOUT_LAST=1 exactly when index = N-1.
  - Transfer on index N-1 without HASH_VALID: go to IDLE; DOUT_VALID, DOUT_LAST and BUSY are 0 next cycle.
  - Transfer on index N-1 with HASH_VALID=1 in the same cycle: capture the new state, index=0, stay in SEND. Next cycle shows new word0 with VALID=1 (back-to-back, zero gap).
  - HASH_VALID in SEND at any other time: new state is discarded, OVERFLOW set to 1 next cycle, and the current digest continues unaffected.
- OVERFLOW:
  - Sticky until reset or CLR_OVERFLOW=1 with CE=1.
  - If a set event and CLR_OVERFLOW occur in the same cycle, set wins.
- N=1: word0 is also last; DOUT_LAST=1 on the first VALID cycle.
- STATE_IN is sampled only on the capture cycle. Later changes, such as the permutation core clearing its state after HASH_VALID, do not affect the output.

Test Plan:
- Reset release, no stimulus: DOUT_VALID=0, BUSY=0, OVERFLOW=0, DOUT=0 for 20 cycles.
- DIGEST_SIZE=256, WORD_WIDTH=64, STATE_IN[0:255] = words 64'h0123456789ABCDEF, 64'h1111..., 64'h2222..., 64'h3333...; HASH_VALID pulse with READY=1 throughout:
  - VALID starts 1 cycle after the pulse.
  - The four words appear in that order on consecutive cycles, DOUT_LAST=1 only on 64'h3333....
  - BUSY falls the cycle after the last transfer.
- Same digest, READY toggled 1,0,0,1,0,1,1: DOUT holds each word while READY=0, no word is lost or duplicated, exactly 4 transfers occur.
- HASH_VALID pulsed while index=1 in SEND: OVERFLOW=1 next cycle, the remaining words come from the original digest, and OVERFLOW stays 1 until CLR_OVERFLOW → OVERFLOW=0 next cycle.
- HASH_VALID coincident with the last-word transfer, new STATE word0 = 64'hDEADBEEFCAFEF00D: next cycle DOUT=64'hDEADBEEFCAFEF00D with VALID=1, BUSY stays 1, OVERFLOW=0.
- BYTE_SWAP=1 with word0 = 64'h0123456789ABCDEF: DOUT=64'hEFCDAB8967452301. A_RST asserted mid-digest clears VALID, BUSY and OVERFLOW asynchronously; after release the block is IDLE.

Source files
------------

// File: rtl/sha3_digest_squeezer.sv
// sha3_digest_squeezer
//
// Consumer end of the Keccak permutation core. On the one-cycle HASH_VALID
// pulse it captures the leading DIGEST_SIZE bits of the 1600-bit state. It
// then streams them out as WORD_WIDTH-bit words over a valid/ready interface.
// BUSY tells the front end that a digest is still draining.
//
// Ports:
//   CLK           rising-edge clock
//   A_RST         asynchronous active-high reset
//   CE            clock enable; every register holds while low
//   STATE_IN      permutation state, bit 0 is the first state bit
//   HASH_VALID    one-cycle pulse, STATE_IN holds the final hash state
//   DOUT          current digest word (DOUT[0] is the first bit)
//   DOUT_VALID    DOUT holds a valid word
//   DOUT_READY    downstream accepts the word
//   DOUT_LAST     DOUT is the final word of the digest
//   BUSY          digest is draining; upstream must not pulse HASH_VALID
//   OVERFLOW      sticky flag, a HASH_VALID was dropped
//   CLR_OVERFLOW  synchronous clear of OVERFLOW (CE-qualified)
module sha3_digest_squeezer #(
    parameter int DIGEST_SIZE = 256,
    parameter int WORD_WIDTH  = 64,
    parameter int BYTE_SWAP   = 0
) (
    input  logic                  CLK,
    input  logic                  A_RST,
    input  logic                  CE,
    input  logic [0:1599]         STATE_IN,
    input  logic                  HASH_VALID,
    output logic [0:WORD_WIDTH-1] DOUT,
    output logic                  DOUT_VALID,
    input  logic                  DOUT_READY,
    output logic                  DOUT_LAST,
    output logic                  BUSY,
    output logic                  OVERFLOW,
    input  logic                  CLR_OVERFLOW
);

    localparam int N      = (DIGEST_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int BUF_W  = N * WORD_WIDTH;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int NBYTES = WORD_WIDTH / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q,  state_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [0:BUF_W-1]      digest_q, digest_d;
    logic [0:WORD_WIDTH-1] dout_q,   dout_d;
    logic                  valid_q,  valid_d;
    logic                  last_q,   last_d;
    logic                  busy_q,   busy_d;
    logic                  ovf_q,    ovf_d;

    logic [0:BUF_W-1] capture;
    logic             transfer;
    logic             at_last;
    logic             load;
    logic             ovf_set;

    // Bits of STATE_IN beyond the digest are never looked at.
    if (DIGEST_SIZE < 1600) begin : g_unused
        logic unused_state_bits;
        assign unused_state_bits = ^STATE_IN[DIGEST_SIZE:1599];
    end

    // Picks word k out of a digest buffer and applies the optional byte
    // reversal. The word mux uses constant slices so it stays a plain mux.
    function automatic logic [0:WORD_WIDTH-1] select_word(
        input logic [0:BUF_W-1] src,
        input logic [IDX_W-1:0] k
    );
        logic [0:WORD_WIDTH-1] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (k == IDX_W'(i)) w = src[i*WORD_WIDTH +: WORD_WIDTH];
        end
        if (BYTE_SWAP != 0) begin
            select_word = '0;
            for (int j = 0; j < NBYTES; j++) begin
                select_word[j*8 +: 8] = w[(NBYTES-1-j)*8 +: 8];
            end
        end else begin
            select_word = w;
        end
    endfunction

    always_comb begin
        // The tail of a partial last word is zero-filled in the buffer.
        capture = '0;
        capture[0:DIGEST_SIZE-1] = STATE_IN[0:DIGEST_SIZE-1];

        transfer = valid_q & DOUT_READY & CE;
        at_last  = (idx_q == LAST_IDX);
        // A new digest is accepted when idle, or in the same cycle the
        // final word leaves, which gives back-to-back digests with no gap.
        load     = HASH_VALID & ((state_q == IDLE) | (transfer & at_last));
        ovf_set  = (state_q == SEND) & HASH_VALID & ~(transfer & at_last);

        state_d  = state_q;
        idx_d    = idx_q;
        digest_d = digest_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
        ovf_d    = ovf_q;

        if (CE) begin
            if (load) begin
                state_d  = SEND;
                idx_d    = '0;
                digest_d = capture;
                dout_d   = select_word(capture, '0);
                valid_d  = 1'b1;
                last_d   = (N == 1);
                busy_d   = 1'b1;
            end else if (transfer) begin
                if (!at_last) begin
                    idx_d  = idx_q + IDX_W'(1);
                    dout_d = select_word(digest_q, idx_d);
                    last_d = (idx_d == LAST_IDX);
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            end

            // Set beats clear when both happen together.
            if (ovf_set) begin
                ovf_d = 1'b1;
            end else if (CLR_OVERFLOW) begin
                ovf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge A_RST) begin
        if (A_RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            digest_q <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            digest_q <= digest_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
        end
    end

    assign DOUT       = dout_q;
    assign DOUT_VALID = valid_q;
    assign DOUT_LAST  = last_q;
    assign BUSY       = busy_q;
    assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_sha3_digest_squeezer.sv
// Bench for sha3_digest_squeezer. Four instances share one stimulus:
//   d0: 256-bit digest, 64-bit words
//   d1: 256-bit digest, 64-bit words, byte swapped
//   d2: 40-bit digest, 16-bit words, byte swapped (partial last word)
//   d3: 32-bit digest, 64-bit words (single, partial word)
// Each instance is compared against a queue-of-words reference model.
module tb_sha3_digest_squeezer;

    localparam int NI   = 4;
    localparam int MAXN = 8;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          ce    = 1'b0;
    logic          hv    = 1'b0;
    logic          ready = 1'b0;
    logic          clr   = 1'b0;
    logic [0:1599] stateIn = '0;

    logic [0:63]   dout0, dout1, dout3;
    logic [0:15]   dout2;
    logic [NI-1:0] valid, last, busy, ovf;

    // Reference model state: the words still owed by each instance.
    logic [255:0] mWords [NI][MAXN];
    int           mHead  [NI];
    int           mCnt   [NI];
    bit           mBusy  [NI];
    bit           mOvf   [NI];

    int checks = 0;
    int errors = 0;

    logic [63:0]  w [4];
    logic [255:0] recv [MAXN];
    int           nXfer;
    logic [0:6]   patt;

    sha3_digest_squeezer #(.DIGEST_SIZE(256), .WORD_WIDTH(64), .BYTE_SWAP(0)) dut0 (
        .CLK(clk), .A_RST(rst), .CE(ce), .STATE_IN(stateIn), .HASH_VALID(hv),
        .DOUT(dout0), .DOUT_VALID(valid[0]), .DOUT_READY(ready), .DOUT_LAST(last[0]),
        .BUSY(busy[0]), .OVERFLOW(ovf[0]), .CLR_OVERFLOW(clr));

    sha3_digest_squeezer #(.DIGEST_SIZE(256), .WORD_WIDTH(64), .BYTE_SWAP(1)) dut1 (
        .CLK(clk), .A_RST(rst), .CE(ce), .STATE_IN(stateIn), .HASH_VALID(hv),
        .DOUT(dout1), .DOUT_VALID(valid[1]), .DOUT_READY(ready), .DOUT_LAST(last[1]),
        .BUSY(busy[1]), .OVERFLOW(ovf[1]), .CLR_OVERFLOW(clr));

    sha3_digest_squeezer #(.DIGEST_SIZE(40), .WORD_WIDTH(16), .BYTE_SWAP(1)) dut2 (
        .CLK(clk), .A_RST(rst), .CE(ce), .STATE_IN(stateIn), .HASH_VALID(hv),
        .DOUT(dout2), .DOUT_VALID(valid[2]), .DOUT_READY(ready), .DOUT_LAST(last[2]),
        .BUSY(busy[2]), .OVERFLOW(ovf[2]), .CLR_OVERFLOW(clr));

    sha3_digest_squeezer #(.DIGEST_SIZE(32), .WORD_WIDTH(64), .BYTE_SWAP(0)) dut3 (
        .CLK(clk), .A_RST(rst), .CE(ce), .STATE_IN(stateIn), .HASH_VALID(hv),
        .DOUT(dout3), .DOUT_VALID(valid[3]), .DOUT_READY(ready), .DOUT_LAST(last[3]),
        .BUSY(busy[3]), .OVERFLOW(ovf[3]), .CLR_OVERFLOW(clr));

    initial forever #5 clk = ~clk;

    function automatic int cfgD(int i);
        case (i)
            0, 1:    return 256;
            2:       return 40;
            default: return 32;
        endcase
    endfunction

    function automatic int cfgW(int i);
        return (i == 2) ? 16 : 64;
    endfunction

    function automatic bit cfgS(int i);
        return (i == 1 || i == 2);
    endfunction

    function automatic int nWords(int i);
        return (cfgD(i) + cfgW(i) - 1) / cfgW(i);
    endfunction

    function automatic logic [255:0] obsDout(int i);
        case (i)
            0:       return 256'(dout0);
            1:       return 256'(dout1);
            2:       return 256'(dout2);
            default: return 256'(dout3);
        endcase
    endfunction

    // Word k of instance i built bit by bit from the current state: first
    // state bit lands in the MSB, bits past the digest read as zero, then
    // the bytes are reversed if that instance swaps.
    function automatic logic [255:0] refWord(int i, int k);
        logic [255:0] wv, r;
        int wd, nb;
        wd = cfgW(i);
        nb = wd / 8;
        wv = '0;
        for (int b = 0; b < wd; b++) begin
            int idx;
            idx = k * wd + b;
            wv = {wv[254:0], (idx < cfgD(i)) ? stateIn[idx] : 1'b0};
        end
        if (cfgS(i)) begin
            r = '0;
            for (int j = 0; j < nb; j++) r[j*8 +: 8] = wv[(nb-1-j)*8 +: 8];
            wv = r;
        end
        return wv;
    endfunction

    task automatic modelLoad(int i);
        for (int k = 0; k < nWords(i); k++) mWords[i][k] = refWord(i, k);
        mHead[i] = 0;
        mCnt[i]  = nWords(i);
        mBusy[i] = 1'b1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NI; i++) begin
            mHead[i] = 0;
            mCnt[i]  = 0;
            mBusy[i] = 1'b0;
            mOvf[i]  = 1'b0;
        end
    endtask

    // One clock of the reference model, using the inputs present at the edge.
    task automatic modelStep();
        for (int i = 0; i < NI; i++) begin
            bit xfer, lastNow, setOvf;
            xfer    = mBusy[i] && ready;
            lastNow = (mCnt[i] == 1);
            setOvf  = 1'b0;
            if (rst) begin
                mHead[i] = 0;
                mCnt[i]  = 0;
                mBusy[i] = 1'b0;
                mOvf[i]  = 1'b0;
            end else if (ce) begin
                if (!mBusy[i]) begin
                    if (hv) modelLoad(i);
                end else begin
                    if (hv && !(xfer && lastNow)) setOvf = 1'b1;
                    if (xfer) begin
                        if (!lastNow) begin
                            mHead[i]++;
                            mCnt[i]--;
                        end else if (hv) begin
                            modelLoad(i);
                        end else begin
                            mBusy[i] = 1'b0;
                            mCnt[i]  = 0;
                        end
                    end
                end
                if (setOvf) mOvf[i] = 1'b1;
                else if (clr) mOvf[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic applyStimulus(input logic h, input logic r, input logic c);
        hv    = h;
        ready = r;
        clr   = c;
    endtask

    task automatic checkEq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int i = 0; i < NI; i++) begin
            checkEq($sformatf("%s d%0d valid", tag, i), valid[i], mBusy[i]);
            checkEq($sformatf("%s d%0d busy", tag, i), busy[i], mBusy[i]);
            checkEq($sformatf("%s d%0d last", tag, i), last[i], mBusy[i] && mCnt[i] == 1);
            checkEq($sformatf("%s d%0d overflow", tag, i), ovf[i], mOvf[i]);
            if (mBusy[i]) checkEq($sformatf("%s d%0d dout", tag, i), obsDout(i), mWords[i][mHead[i]]);
        end
    endtask

    task automatic randomState();
        for (int b = 0; b < 1600; b += 32) stateIn[b +: 32] = $urandom;
    endtask

    // Known digest words with random state bits everywhere else.
    task automatic loadState(input logic [63:0] first);
        randomState();
        stateIn[0:63]    = first;
        stateIn[64:127]  = w[1];
        stateIn[128:191] = w[2];
        stateIn[192:255] = w[3];
    endtask

    initial begin
        w[0] = 64'h0123456789ABCDEF;
        w[1] = 64'h1111111111111111;
        w[2] = 64'h2222222222222222;
        w[3] = 64'h3333333333333333;

        $display("[TB] reset and idle");
        ce  = 1'b1;
        rst = 1'b1;
        modelReset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checkOutput("idle");
            for (int i = 0; i < NI; i++) checkEq($sformatf("idle d%0d dout zero", i), obsDout(i), '0);
        end

        $display("[TB] streaming with ready held high");
        loadState(w[0]);
        applyStimulus(1, 1, 0);
        tick();
        applyStimulus(0, 1, 0);
        stateIn = '0;
        checkOutput("stream first");
        checkEq("stream valid latency", valid[0], 1'b1);
        checkEq("stream word0", obsDout(0), w[0]);
        checkEq("stream last word0", last[0], 1'b0);
        checkEq("stream swapped word0", obsDout(1), 64'hEFCDAB8967452301);
        for (int k = 1; k < 4; k++) begin
            tick();
            checkOutput("stream");
            checkEq($sformatf("stream word%0d", k), obsDout(0), w[k]);
            checkEq($sformatf("stream last%0d", k), last[0], k == 3);
        end
        tick();
        checkOutput("stream end");
        checkEq("stream busy fall", busy[0], 1'b0);

        $display("[TB] ready pattern 1,0,0,1,0,1,1");
        loadState(w[0]);
        applyStimulus(1, 0, 0);
        tick();
        checkOutput("pattern start");
        patt  = 7'b1001011;
        nXfer = 0;
        for (int p = 0; p < 7; p++) begin
            applyStimulus(0, patt[p], 0);
            if (valid[0] && patt[p]) begin
                if (nXfer < MAXN) recv[nXfer] = obsDout(0);
                nXfer++;
            end
            tick();
            checkOutput("pattern");
        end
        applyStimulus(0, 0, 0);
        repeat (2) begin
            tick();
            checkOutput("pattern tail");
        end
        checkEq("pattern transfers", nXfer, 4);
        for (int k = 0; k < 4; k++) checkEq($sformatf("pattern word%0d", k), recv[k], w[k]);
        checkEq("pattern idle", busy[0], 1'b0);

        $display("[TB] dropped hash sets overflow");
        loadState(w[0]);
        applyStimulus(1, 1, 0);
        tick();
        applyStimulus(0, 1, 0);
        tick();
        checkEq("ovf at index1", obsDout(0), w[1]);
        randomState();
        applyStimulus(1, 1, 0);
        tick();
        applyStimulus(0, 1, 0);
        checkOutput("ovf set");
        checkEq("ovf flag set", ovf[0], 1'b1);
        checkEq("ovf word2 kept", obsDout(0), w[2]);
        tick();
        checkOutput("ovf word3");
        checkEq("ovf word3 kept", obsDout(0), w[3]);
        repeat (4) begin
            tick();
            checkOutput("ovf sticky");
            checkEq("ovf still set", ovf[0], 1'b1);
        end
        applyStimulus(0, 0, 1);
        tick();
        applyStimulus(0, 0, 0);
        checkOutput("ovf clear");
        checkEq("ovf cleared", ovf[0], 1'b0);

        $display("[TB] back-to-back digest on last transfer");
        loadState(w[0]);
        applyStimulus(1, 1, 0);
        tick();
        applyStimulus(0, 1, 0);
        repeat (3) begin
            tick();
            checkOutput("b2b drain");
        end
        checkEq("b2b at last", last[0], 1'b1);
        loadState(64'hDEADBEEFCAFEF00D);
        applyStimulus(1, 1, 0);
        tick();
        applyStimulus(0, 1, 0);
        checkOutput("b2b next");
        checkEq("b2b new word0", obsDout(0), 64'hDEADBEEFCAFEF00D);
        checkEq("b2b valid", valid[0], 1'b1);
        checkEq("b2b busy", busy[0], 1'b1);
        checkEq("b2b no overflow", ovf[0], 1'b0);
        repeat (5) begin
            tick();
            checkOutput("b2b tail");
        end

        $display("[TB] asynchronous reset mid-digest");
        loadState(w[0]);
        applyStimulus(1, 1, 0);
        tick();
        applyStimulus(0, 1, 0);
        tick();
        applyStimulus(1, 1, 0);
        tick();
        applyStimulus(0, 1, 0);
        checkEq("arst ovf before", ovf[0], 1'b1);
        checkEq("arst valid before", valid[0], 1'b1);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("arst async");
        checkEq("arst valid drop", valid[0], 1'b0);
        checkEq("arst busy drop", busy[0], 1'b0);
        checkEq("arst ovf drop", ovf[0], 1'b0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("arst idle");
        checkEq("arst idle busy", busy[0], 1'b0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            randomState();
            ce = ($urandom_range(0, 7) != 0);
            applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
            tick();
            checkOutput("random");
        end
        ce = 1'b1;
        applyStimulus(0, 1, 0);
        repeat (10) begin
            tick();
            checkOutput("random drain");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
